// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory bus between the instruction-fetch port and the load/store
// port. Only one bus transaction is outstanding at a time.
// Data requests are aligned into a word address, byte enables and
// lane-replicated write data. Load data is returned extracted and extended.
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   if_*                  fetch port: req/addr in; gnt/rvalid/rdata/err out
//   lsu_*                 data port: req/we/width/signed/addr/wdata in;
//                         gnt/rvalid/rdata/err out
//   bus_*                 memory bus: req/we/addr/be/wdata out; gnt/rvalid/rdata/err in
module mem_port_arbiter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_width_i,
    input  logic        lsu_signed_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    // Legality of a data access for a given width and byte offset.
    function automatic logic lsu_legal(input logic [1:0] width, input logic [1:0] idx);
        logic ok;
        case (width)
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~idx[0];
            2'b10:   ok = (idx == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-enable pattern for a data access.
    function automatic logic [3:0] lsu_be(input logic [1:0] width, input logic [1:0] idx);
        logic [3:0] be;
        case (width)
            2'b00:   be = 4'b0001 << idx;
            2'b01:   be = 4'b0011 << idx;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data onto every lane it may occupy.
    function automatic logic [31:0] lsu_wdata(input logic [1:0] width, input logic [31:0] wd);
        logic [31:0] r;
        case (width)
            2'b00:   r = {4{wd[7:0]}};
            2'b01:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Extract the addressed byte/half from a bus word and extend it.
    // Halves are always aligned, so idx*8 also lands on the right half.
    function automatic logic [31:0] load_extend(input logic [1:0] width, input logic sgn,
                                                input logic [1:0] idx, input logic [31:0] word);
        logic [15:0] sh;
        logic [31:0] r;
        sh = 16'(word >> {idx, 3'b000});
        case (width)
            2'b00:   r = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   r = {{16{sgn & sh[15]}}, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic        last_owner_q, last_owner_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic        signed_q, signed_d;
    logic [1:0]  width_q, width_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_err_q, if_err_d;
    logic        lsu_rvalid_q, lsu_rvalid_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;
    logic        lsu_err_q, lsu_err_d;
    logic        if_gnt_s, lsu_gnt_s;
    logic        fetch_win_s, lsu_win_s;

    // Arbitration: a lone requester wins; on a tie the port not served last wins.
    assign fetch_win_s = if_req_i & (~lsu_req_i | (last_owner_q == OWN_DATA));
    assign lsu_win_s   = lsu_req_i & (~if_req_i | (last_owner_q == OWN_FETCH));

    // Next-state, grant and response logic.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        we_d         = we_q;
        signed_d     = signed_q;
        width_d      = width_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        if_rvalid_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        if_err_d     = if_err_q;
        lsu_rvalid_d = 1'b0;
        lsu_rdata_d  = lsu_rdata_q;
        lsu_err_d    = lsu_err_q;
        if_gnt_s     = 1'b0;
        lsu_gnt_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fetch_win_s) begin
                    if_gnt_s     = 1'b1;
                    owner_d      = OWN_FETCH;
                    last_owner_d = OWN_FETCH;
                    we_d         = 1'b0;
                    addr_d       = if_addr_i & 32'hFFFF_FFFC;
                    be_d         = 4'b0000;
                    wdata_d      = 32'h0000_0000;
                    state_d      = S_REQ;
                end else if (lsu_win_s) begin
                    lsu_gnt_s    = 1'b1;
                    owner_d      = OWN_DATA;
                    last_owner_d = OWN_DATA;
                    we_d         = lsu_we_i;
                    signed_d     = lsu_signed_i;
                    width_d      = lsu_width_i;
                    idx_d        = lsu_addr_i[1:0];
                    if (lsu_legal(lsu_width_i, lsu_addr_i[1:0])) begin
                        addr_d  = {lsu_addr_i[31:2], 2'b00};
                        be_d    = lsu_we_i ? lsu_be(lsu_width_i, lsu_addr_i[1:0]) : 4'b0000;
                        wdata_d = lsu_we_i ? lsu_wdata(lsu_width_i, lsu_wdata_i) : 32'h0000_0000;
                        state_d = S_REQ;
                    end else begin
                        // No bus transaction; the error is reported from S_ERR.
                        state_d = S_ERR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus_gnt_i) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (bus_rvalid_i) begin
                    state_d = S_IDLE;
                    if (owner_q == OWN_FETCH) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = bus_rdata_i;
                        if_err_d    = bus_err_i;
                    end else begin
                        lsu_rvalid_d = 1'b1;
                        lsu_rdata_d  = (we_q | bus_err_i) ? 32'h0000_0000
                                     : load_extend(width_q, signed_q, idx_q, bus_rdata_i);
                        lsu_err_d    = bus_err_i;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ERR: begin
                lsu_rvalid_d = 1'b1;
                lsu_rdata_d  = 32'h0000_0000;
                lsu_err_d    = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, request-field and response registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            last_owner_q <= OWN_FETCH;
            owner_q      <= OWN_FETCH;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            width_q      <= 2'b00;
            idx_q        <= 2'b00;
            addr_q       <= 32'h0000_0000;
            be_q         <= 4'b0000;
            wdata_q      <= 32'h0000_0000;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= 32'h0000_0000;
            if_err_q     <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            lsu_rdata_q  <= 32'h0000_0000;
            lsu_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            signed_q     <= signed_d;
            width_q      <= width_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            if_err_q     <= if_err_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            lsu_rdata_q  <= lsu_rdata_d;
            lsu_err_q    <= lsu_err_d;
        end
    end

    assign if_gnt_o     = if_gnt_s;
    assign lsu_gnt_o    = lsu_gnt_s;
    assign if_rvalid_o  = if_rvalid_q;
    assign if_rdata_o   = if_rdata_q;
    assign if_err_o     = if_err_q;
    assign lsu_rvalid_o = lsu_rvalid_q;
    assign lsu_rdata_o  = lsu_rdata_q;
    assign lsu_err_o    = lsu_err_q;
    assign bus_req_o    = (state_q == S_REQ);
    assign bus_we_o     = we_q;
    assign bus_addr_o   = addr_q;
    assign bus_be_o     = be_q;
    assign bus_wdata_o  = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter. The stimulus pushes expected
// port responses and expected bus requests into queues; a bus model and a
// response monitor pop and compare them independently.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_i, if_gnt_o, if_rvalid_o, if_err_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        lsu_req_i, lsu_we_i, lsu_signed_i, lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
    logic [1:0]  lsu_width_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
    logic        bus_req_o, bus_we_o, bus_gnt_i, bus_rvalid_i, bus_err_i;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_be_o;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_width_i(lsu_width_i),
        .lsu_signed_i(lsu_signed_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .lsu_err_o(lsu_err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
    );

    typedef struct {
        bit          port;   // 0 fetch, 1 data
        logic [31:0] rdata;
        bit          err;
        int          gcyc;
        int          lat;    // -1: latency not checked
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          we;
        bit          chk_wd;
        int          gcyc;
    } bus_t;

    rsp_t        sb[$];
    bus_t        exp_bus[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          stall = 0;
    int          gap = 0;
    int          rv_pulses = 0;
    logic [31:0] resp_data = 32'h0;
    logic        resp_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [139:0] all_outs();
        return {if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o, lsu_gnt_o, lsu_rvalid_o,
                lsu_rdata_o, lsu_err_o, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o};
    endfunction

    function automatic logic [69:0] bus_fields();
        return {bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o};
    endfunction

    task automatic chk_all_zero(input string name);
        checks++;
        if (all_outs() !== 140'd0) begin
            errors++;
            $display("FAIL %s actual=%h required=0", name, all_outs());
        end
    endtask

    // Response monitor: every rvalid pulse is matched against the scoreboard.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_n && (if_rvalid_o || lsu_rvalid_o)) begin
                rv_pulses++;
                chk("rvalid_exclusive", {31'd0, if_rvalid_o & lsu_rvalid_o}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid actual=if%0b/lsu%0b required=none",
                             if_rvalid_o, lsu_rvalid_o);
                end else begin
                    r = sb.pop_front();
                    chk("rsp_port", {31'd0, lsu_rvalid_o}, {31'd0, r.port});
                    chk("rsp_rdata", r.port ? lsu_rdata_o : if_rdata_o, r.rdata);
                    chk("rsp_err", {31'd0, r.port ? lsu_err_o : if_err_o}, {31'd0, r.err});
                    if (r.lat >= 0) chk("rsp_latency", 32'(cyc - r.gcyc), 32'(r.lat));
                end
            end
        end
    end

    // Bus model: stalls the grant, checks request fields, then responds.
    initial begin
        bus_t        e;
        logic [69:0] cap;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0; bus_err_i = 1'b0;
        forever begin
            @(negedge clk);
            bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
            if (rst_n && bus_req_o) begin
                if (exp_bus.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bus_req actual=addr %h required=no request", bus_addr_o);
                end else begin
                    e = exp_bus.pop_front();
                    chk("bus_req_cycle", 32'(cyc), 32'(e.gcyc + 1));
                    cap = bus_fields();
                    for (int k = 0; k < stall; k++) begin
                        @(negedge clk);
                        checks++;
                        if (bus_fields() !== cap) begin
                            errors++;
                            $display("FAIL bus_stable actual=%h required=%h", bus_fields(), cap);
                        end
                    end
                    chk("bus_addr", bus_addr_o, e.addr);
                    chk("bus_be", {28'd0, bus_be_o}, {28'd0, e.be});
                    chk("bus_we", {31'd0, bus_we_o}, {31'd0, e.we});
                    if (e.chk_wd) chk("bus_wdata", bus_wdata_o, e.wdata);
                    bus_gnt_i = 1'b1;
                    @(negedge clk);
                    bus_gnt_i = 1'b0;
                    chk("bus_req_dropped", {31'd0, bus_req_o}, 32'd0);
                    for (int k = 0; k < gap; k++) @(negedge clk);
                    bus_rvalid_i = 1'b1;
                    bus_rdata_i  = resp_data;
                    bus_err_i    = resp_err;
                end
            end
        end
    end

    task automatic wait_idle();
        bit done = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic issue(input bit port, input bit we, input logic [1:0] width, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input bit legal,
                         input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input bit chk_wd,
                         input logic [31:0] e_rdata, input bit e_err, input bit wait_done);
        bit   got = 1'b0;
        rsp_t r;
        bus_t b;
        @(negedge clk);
        if (port) begin
            lsu_req_i = 1'b1; lsu_we_i = we; lsu_width_i = width;
            lsu_signed_i = sgn; lsu_addr_i = addr; lsu_wdata_i = wd;
        end else begin
            if_req_i = 1'b1; if_addr_i = addr;
        end
        for (int t = 0; t < 100; t++) begin
            #1;
            if (port ? lsu_gnt_o : if_gnt_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout actual=0 required=1 addr %h", addr);
            if_req_i = 1'b0; lsu_req_i = 1'b0;
            return;
        end
        chk("gnt_exclusive", {31'd0, port ? if_gnt_o : lsu_gnt_o}, 32'd0);
        r.port = port; r.rdata = e_rdata; r.err = e_err; r.gcyc = cyc; r.lat = legal ? 3 : 2;
        sb.push_back(r);
        if (legal) begin
            b.addr = e_addr; b.be = e_be; b.wdata = e_wd; b.we = port & we;
            b.chk_wd = chk_wd; b.gcyc = cyc;
            exp_bus.push_back(b);
        end
        @(posedge clk);
        #1;
        if_req_i = 1'b0; lsu_req_i = 1'b0;
        if (wait_done) wait_idle();
    endtask

    // Both ports request continuously; grants must alternate starting with data.
    task automatic arb_test();
        bit [3:0] order = 4'b0;
        int       n = 0;
        rsp_t     r;
        bus_t     b;
        stall = 5; resp_data = 32'h1234_5678; resp_err = 1'b0;
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h0000_0800;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_width_i = 2'b10; lsu_signed_i = 1'b0;
        lsu_addr_i = 32'h0000_0900; lsu_wdata_i = 32'h0;
        for (int t = 0; t < 400 && n < 4; t++) begin
            #1;
            if (if_gnt_o || lsu_gnt_o) begin
                chk("gnt_exclusive", {31'd0, if_gnt_o & lsu_gnt_o}, 32'd0);
                order[n] = lsu_gnt_o;
                r.port = lsu_gnt_o; r.rdata = 32'h1234_5678; r.err = 1'b0;
                r.gcyc = cyc; r.lat = -1;
                sb.push_back(r);
                b.addr = lsu_gnt_o ? 32'h0000_0900 : 32'h0000_0800;
                b.be = 4'b0000; b.wdata = 32'h0; b.we = 1'b0; b.chk_wd = 1'b0; b.gcyc = cyc;
                exp_bus.push_back(b);
                n++;
                if (n == 4) begin
                    @(posedge clk);
                    #1;
                    if_req_i = 1'b0; lsu_req_i = 1'b0;
                end
            end
            if (n < 4) @(negedge clk);
        end
        if_req_i = 1'b0; lsu_req_i = 1'b0;
        chk("arb_grant_count", 32'(n), 32'd4);
        chk("arb_order", {28'd0, order}, 32'h0000_0005);
        wait_idle();
        stall = 0;
    endtask

    initial begin
        int rv0;
        rst_n = 1'b0;
        if_req_i = 1'b0; if_addr_i = 32'h0;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_width_i = 2'b00; lsu_signed_i = 1'b0;
        lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;

        arb_test();

        // Fetch 0x100, zero-wait bus.
        resp_data = 32'hDEAD_BEEF;
        issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 1'b1,
              32'h0000_0100, 4'b0000, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        // Byte loads at 0x203, signed then unsigned; signed half at 0x202.
        resp_data = 32'h80FF_0000;
        issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0, 1'b1,
              32'h0000_0200, 4'b0000, 32'h0, 1'b0, 32'hFFFF_FF80, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0, 1'b1,
              32'h0000_0200, 4'b0000, 32'h0, 1'b0, 32'h0000_0080, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 1'b1,
              32'h0000_0200, 4'b0000, 32'h0, 1'b0, 32'hFFFF_80FF, 1'b0, 1'b1);
        // Half store 0xABCD at 0x302; byte store 0x5A at 0x101.
        resp_data = 32'hFFFF_FFFF;
        issue(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0302, 32'h0000_ABCD, 1'b1,
              32'h0000_0300, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_565A, 1'b1,
              32'h0000_0100, 4'b0010, 32'h5A5A_5A5A, 1'b1, 32'h0, 1'b0, 1'b1);
        // Misaligned word load and illegal width: no bus request.
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0401, 32'h0, 1'b0,
              32'h0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0404, 32'h0, 1'b0,
              32'h0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        // Bus error on a word load.
        resp_data = 32'h1111_1111; resp_err = 1'b1;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0700, 32'h0, 1'b1,
              32'h0000_0700, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        resp_err = 1'b0;

        // Reset while in WAIT; the late bus response must be discarded.
        resp_data = 32'hCAFE_F00D; gap = 3;
        issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0600, 32'h0, 1'b1,
              32'h0000_0600, 4'b0000, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        chk_all_zero("reset_midflight_outputs");
        rv0 = rv_pulses;
        repeat (6) @(negedge clk);
        chk("reset_no_rvalid", 32'(rv_pulses - rv0), 32'd0);
        gap = 0;
        resp_data = 32'h0BAD_F00D;
        issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0604, 32'h0, 1'b1,
              32'h0000_0604, 4'b0000, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
